gpio_bank_mmio: RTL and testbench

GPIO_BANK_MMIO -- requirements
Module: gpio_bank_mmio

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_sync.sv | 29 ++
 rtl/gpio_bank_mmio.sv | 170 +++++++++++++++++
 tb/tb_gpio_bank_mmio.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank: register word offsets,
// edge-select encoding and the input warm-up states.
package gpio_pkg;

  // Word index (addr[7:2]); byte offsets are 0x00..0x1C.
  typedef enum logic [5:0] {
    REG_OUT        = 6'h00,
    REG_DIR        = 6'h01,
    REG_IN         = 6'h02,
    REG_IRQ_EN     = 6'h03,
    REG_IRQ_STATUS = 6'h04,
    REG_EDGE_SEL   = 6'h05,
    REG_OUT_SET    = 6'h06,
    REG_OUT_CLR    = 6'h07
  } gpio_reg_e;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } gpio_edge_e;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } gpio_warm_e;

  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:8] == base[31:8];
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_bank_mmio.sv
// Memory-mapped GPIO bank: output/direction registers, synchronized inputs,
// per-pin edge interrupts with W1C status and a registered load port.
module gpio_bank_mmio
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq
);

  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] in_dly_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;

  gpio_warm_e       warm_state_q;
  logic [2:0]       warm_cnt_q;
  logic             detect_en_q;

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rise, fall, edge_evt;
  logic [31:0]      rd_val;
  logic             hit, wr_hit, rd_hit;
  gpio_reg_e        reg_sel;
  logic             unused_bits;

  gpio_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (WIDTH)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(pins_in),
    .q_o(in_sync)
  );

  assign hit     = addr_hit(addr, BASE_ADDR);
  assign wr_hit  = we && hit;
  assign rd_hit  = re && hit;
  assign reg_sel = gpio_reg_e'(addr[7:2]);
  assign wr_val  = wdata[WIDTH-1:0];

  assign unused_bits = ^{addr[1:0], wdata};

  // Pins already high at reset must not look like edges while the chain fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_state_q <= ST_WARM;
      warm_cnt_q   <= '0;
      detect_en_q  <= 1'b0;
    end else begin
      case (warm_state_q)
        ST_WARM: begin
          if (warm_cnt_q == WARM_LAST) begin
            warm_state_q <= ST_RUN;
            detect_en_q  <= 1'b1;
          end else begin
            warm_cnt_q <= warm_cnt_q + 3'd1;
          end
        end
        ST_RUN:  detect_en_q <= 1'b1;
        default: warm_state_q <= ST_WARM;
      endcase
    end
  end

  assign rise = in_sync & ~in_dly_q;
  assign fall = ~in_sync & in_dly_q;

  always_comb begin
    edge_evt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (gpio_edge_e'(edge_sel_q[i]) == EDGE_FALL) begin
        edge_evt[i] = detect_en_q && fall[i];
      end else begin
        edge_evt[i] = detect_en_q && rise[i];
      end
    end
  end

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    w1c_mask   = '0;
    if (wr_hit) begin
      case (reg_sel)
        REG_OUT:        out_d      = wr_val;
        REG_DIR:        dir_d      = wr_val;
        REG_IRQ_EN:     irq_en_d   = wr_val;
        REG_IRQ_STATUS: w1c_mask   = wr_val;
        REG_EDGE_SEL:   edge_sel_d = wr_val;
        REG_OUT_SET:    out_d      = out_q | wr_val;
        REG_OUT_CLR:    out_d      = out_q & ~wr_val;
        default:        ;
      endcase
    end
    // A fresh event outranks a same-cycle clear.
    status_d = (status_q & ~w1c_mask) | edge_evt;
  end

  always_comb begin
    case (reg_sel)
      REG_OUT:        rd_val = 32'(out_q);
      REG_DIR:        rd_val = 32'(dir_q);
      REG_IN:         rd_val = 32'(in_sync);
      REG_IRQ_EN:     rd_val = 32'(irq_en_q);
      REG_IRQ_STATUS: rd_val = 32'(status_q);
      REG_EDGE_SEL:   rd_val = 32'(edge_sel_q);
      default:        rd_val = '0;
    endcase
    rdata_d  = rd_hit ? rd_val : '0;
    rvalid_d = rd_hit;
    irq_d    = |(status_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      status_q   <= '0;
      edge_sel_q <= '0;
      in_dly_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      edge_sel_q <= edge_sel_d;
      in_dly_q   <= in_sync;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign pins_out = out_q;
  assign pins_oe  = dir_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank_mmio.sv
// Scoreboarded random and directed bench for gpio_bank_mmio against a
// cycle-level reference model of the register map and pin behaviour.
module tb_gpio_bank_mmio;

  localparam int unsigned W    = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned S    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [W-1:0]  pins_in = '0;
  logic [W-1:0]  pins_out;
  logic [W-1:0]  pins_oe;
  logic          irq;

  always #5 clk = ~clk;

  gpio_bank_mmio #(
    .WIDTH      (W),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .pins_in (pins_in),
    .pins_out(pins_out),
    .pins_oe (pins_oe),
    .irq     (irq)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        mon_en = 1'b0;

  // Reference model state
  logic [W-1:0] m_out, m_dir, m_en, m_stat, m_sel, m_in, m_in_prev;
  logic         m_irq, m_rv, m_rd_zero;
  int unsigned  m_since;
  logic [W-1:0] m_pipe[$];
  logic [31:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_sel = '0;
    m_in = '0; m_in_prev = '0; m_irq = 1'b0; m_rv = 1'b0; m_rd_zero = 1'b1;
    m_since = 0;
    m_pipe.delete();
    for (int i = 0; i < int'(S) - 1; i++) m_pipe.push_back('0);
  endtask

  // Apply one clock edge of the register-map rules to the model.
  task automatic m_step();
    logic         hit;
    logic [5:0]   off;
    logic [W-1:0] wd, evt, w1c;
    logic [31:0]  rv;
    if (rst) begin
      m_reset();
      return;
    end
    hit = (addr[31:8] == BASE[31:8]);
    off = addr[7:2];
    wd  = wdata[W-1:0];
    m_rv      = re && hit;
    m_rd_zero = re && !hit;
    if (re && hit) begin
      case (off)
        6'd0:    rv = 32'(m_out);
        6'd1:    rv = 32'(m_dir);
        6'd2:    rv = 32'(m_in);
        6'd3:    rv = 32'(m_en);
        6'd4:    rv = 32'(m_stat);
        6'd5:    rv = 32'(m_sel);
        default: rv = 32'd0;
      endcase
      exp_q.push_back(rv);
    end
    evt = '0;
    if (m_since >= S + 1) begin
      for (int i = 0; i < int'(W); i++) begin
        if (m_sel[i]) evt[i] = m_in_prev[i] && !m_in[i];
        else          evt[i] = !m_in_prev[i] && m_in[i];
      end
    end
    w1c   = (we && hit && off == 6'd4) ? wd : '0;
    m_irq = |(m_stat & m_en);
    if (we && hit) begin
      case (off)
        6'd0: m_out = wd;
        6'd1: m_dir = wd;
        6'd3: m_en  = wd;
        6'd5: m_sel = wd;
        6'd6: m_out = m_out | wd;
        6'd7: m_out = m_out & ~wd;
        default: ;
      endcase
    end
    m_stat    = (m_stat & ~w1c) | evt;
    m_in_prev = m_in;
    m_pipe.push_back(pins_in);
    m_in = m_pipe.pop_front();
    if (m_since < 1000) m_since++;
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each rvalid.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("rvalid", 32'(rvalid), 32'(m_rv));
        if (rvalid) begin
          if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
          else                   chk("rdata", rdata, exp_q.pop_front());
        end
        if (m_rd_zero) chk("rdata_zero", rdata, 32'd0);
        chk("pins_out", 32'(pins_out), 32'(m_out));
        chk("pins_oe", 32'(pins_oe), 32'(m_dir));
        chk("irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    addr = BASE | 32'(off); wdata = d; we = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off);
    addr = BASE | 32'(off); re = 1'b1;
    cycle();
    re = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    m_reset();
    // Reset with pins held high, then let the warm-up window pass.
    pins_in = 4'hF; rst = 1'b1;
    cycle(); cycle();
    mon_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_oe", 32'(pins_oe), 32'd0);
    rd(8'h10);
    chk("rst_status", rdata, 32'd0);

    // OUT, OUT_SET, OUT_CLR
    wr(8'h00, 32'h5); chk("set_clr_out0", 32'(pins_out), 32'h5);
    wr(8'h18, 32'hA); chk("set_clr_out1", 32'(pins_out), 32'hF);
    wr(8'h1C, 32'h1); chk("set_clr_out2", 32'(pins_out), 32'hE);
    rd(8'h00);
    chk("read_out_valid", 32'(rvalid), 32'd1);
    chk("read_out_data", rdata, 32'hE);
    cycle();
    chk("read_out_one_shot", 32'(rvalid), 32'd0);

    // Rising edge on pin 0
    pins_in = '0;
    for (int i = 0; i < int'(S) + 3; i++) cycle();
    wr(8'h10, 32'hF);
    wr(8'h0C, 32'h1);
    wr(8'h14, 32'h0);
    pins_in = 4'h1;
    for (int i = 0; i < int'(S) + 1; i++) cycle();
    chk("rise_irq_before", 32'(irq), 32'd0);
    cycle();
    chk("rise_irq_after", 32'(irq), 32'd1);
    rd(8'h10);
    chk("rise_status", rdata, 32'h1);
    wr(8'h10, 32'h1);
    chk("w1c_irq_hold", 32'(irq), 32'd1);
    cycle();
    chk("w1c_irq_clear", 32'(irq), 32'd0);

    // Falling edge on pin 2 collides with W1C of bit 2
    wr(8'h14, 32'h4);
    pins_in = 4'h5;
    for (int i = 0; i < int'(S) + 3; i++) cycle();
    wr(8'h10, 32'hF);
    pins_in = 4'h1;
    for (int i = 0; i < int'(S); i++) cycle();
    wr(8'h10, 32'h4);
    rd(8'h10);
    chk("collision_status", rdata, 32'h4);

    // Address decode
    addr = 32'h0000_0008; re = 1'b1; cycle(); re = 1'b0;
    chk("nomatch_rvalid", 32'(rvalid), 32'd0);
    chk("nomatch_rdata", rdata, 32'd0);
    rd(8'h20);
    chk("unmapped_rvalid", 32'(rvalid), 32'd1);
    chk("unmapped_rdata", rdata, 32'd0);
    wr(8'h04, 32'hFFFF_FFFF);
    rd(8'h04);
    chk("dir_mask", rdata, 32'h0000_000F);

    // Read-during-write returns the old value; reset cancels a load
    addr = BASE; wdata = 32'h3; we = 1'b1; re = 1'b1; cycle(); we = 1'b0; re = 1'b0;
    chk("rdw_old", rdata, 32'hE);
    addr = BASE; re = 1'b1; rst = 1'b1; cycle(); re = 1'b0; rst = 1'b0;
    chk("rst_cancel_rvalid", 32'(rvalid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 2) == 0);
      re  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
      end else begin
        a = {BASE[31:8], 6'($urandom_range(0, 9)), 2'($urandom)};
      end
      addr  = a;
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) pins_in = W'($urandom);
      cycle();
    end
    rst = 1'b0; we = 1'b0; re = 1'b0;
    cycle(); cycle();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
